// File: rtl/i2c_pt_pkg.sv
`default_nettype none
// i2c_pt_pkg -- line state encoding and hold-off defaults for the open-drain repeater. Rev 1.0
package i2c_pt_pkg;

   localparam int HOLD_W = 8;

   // Line 1 (SCL) gets the longer hold-off, line 0 (SDA) the shorter one.
   localparam logic [2*HOLD_W-1:0] HOLD_CYCLES_DEFAULT = {8'd15, 8'd7};

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      A2B   = 3'd1,
      B2A   = 3'd2,
      HOLD  = 3'd3,
      STUCK = 3'd4
   } line_state_t;

endpackage
`default_nettype wire

// File: rtl/i2c_pt_line.sv
`default_nettype none
// i2c_pt_line -- one repeated open-drain line: synchronisers, glitch filters, drive FSM, fault flag. Rev 1.0
module i2c_pt_line
   import i2c_pt_pkg::*;
#(
   parameter int                FILT_LEN = 3,
   parameter logic [HOLD_W-1:0] HOLD_LEN = 8'd7,
   parameter int                TIMEOUT  = 240000,
   parameter int                TO_W     = 20
) (
   input  logic clk,
   input  logic rst,
   input  logic enable,
   input  logic fault_clr,
   input  logic a_in,
   input  logic b_in,
   output logic a_oe,
   output logic b_oe,
   output logic active,
   output logic dir,
   output logic fault
);

   localparam logic [3:0]      FILT_LAST = 4'(FILT_LEN - 1);
   localparam logic [TO_W-1:0] TO_LAST   = TO_W'(TIMEOUT - 1);

   // Index 0 is side A, index 1 is side B.
   logic [1:0] raw;
   logic [1:0] sync1;
   logic [1:0] sync2;
   logic [1:0] filt;
   logic [3:0] fcnt [2];

   assign raw = {b_in, a_in};

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1   <= 2'b11;
         sync2   <= 2'b11;
         filt    <= 2'b11;
         fcnt[0] <= 4'd0;
         fcnt[1] <= 4'd0;
      end else begin
         sync1 <= raw;
         sync2 <= sync1;
         for (int p = 0; p < 2; p++) begin
            if (sync2[p] == filt[p]) begin
               fcnt[p] <= 4'd0;
            end else if (fcnt[p] == FILT_LAST) begin
               filt[p] <= sync2[p];
               fcnt[p] <= 4'd0;
            end else begin
               fcnt[p] <= fcnt[p] + 4'd1;
            end
         end
      end
   end

   logic              filt_a;
   logic              filt_b;
   logic              to_hit;
   line_state_t       state;
   logic [HOLD_W-1:0] hold_cnt;
   logic [TO_W-1:0]   to_cnt;

   assign filt_a = filt[0];
   assign filt_b = filt[1];
   assign to_hit = (TIMEOUT != 0) && (to_cnt == TO_LAST);

   // Only the originating side's filtered level can end a drive state, so the
   // low we echo onto the other side never holds the line up by itself.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         a_oe     <= 1'b0;
         b_oe     <= 1'b0;
         active   <= 1'b0;
         dir      <= 1'b0;
         fault    <= 1'b0;
         hold_cnt <= '0;
         to_cnt   <= '0;
      end else begin
         if (fault_clr) begin
            fault <= 1'b0;
         end
         if (!enable) begin
            state    <= IDLE;
            a_oe     <= 1'b0;
            b_oe     <= 1'b0;
            active   <= 1'b0;
            dir      <= 1'b0;
            hold_cnt <= '0;
            to_cnt   <= '0;
         end else begin
            case (state)
               IDLE: begin
                  if (!filt_a) begin
                     state  <= A2B;
                     b_oe   <= 1'b1;
                     dir    <= 1'b1;
                     active <= 1'b1;
                     to_cnt <= '0;
                  end else if (!filt_b) begin
                     state  <= B2A;
                     a_oe   <= 1'b1;
                     active <= 1'b1;
                     to_cnt <= '0;
                  end
               end
               A2B, B2A: begin
                  if ((state == A2B) ? filt_a : filt_b) begin
                     state    <= HOLD;
                     a_oe     <= 1'b0;
                     b_oe     <= 1'b0;
                     dir      <= 1'b0;
                     hold_cnt <= HOLD_LEN;
                  end else if (to_hit) begin
                     // Set after the clear above so a coincident new fault wins.
                     state <= STUCK;
                     a_oe  <= 1'b0;
                     b_oe  <= 1'b0;
                     dir   <= 1'b0;
                     fault <= 1'b1;
                  end else begin
                     to_cnt <= to_cnt + TO_W'(1);
                  end
               end
               HOLD: begin
                  if (hold_cnt == '0) begin
                     state  <= IDLE;
                     active <= 1'b0;
                  end else begin
                     hold_cnt <= hold_cnt - HOLD_W'(1);
                  end
               end
               STUCK: begin
                  if (filt_a && filt_b) begin
                     state    <= HOLD;
                     hold_cnt <= HOLD_LEN;
                  end
               end
               default: begin
                  state  <= IDLE;
                  a_oe   <= 1'b0;
                  b_oe   <= 1'b0;
                  active <= 1'b0;
                  dir    <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/i2c_passthrough_n.sv
`default_nettype none
// i2c_passthrough_n -- N-line bidirectional open-drain repeater between side A and side B. Rev 1.0
module i2c_passthrough_n
   import i2c_pt_pkg::*;
#(
   parameter int                          N_LINES     = 2,
   parameter int                          FILT_LEN    = 3,
   parameter logic [N_LINES*HOLD_W-1:0]   HOLD_CYCLES = HOLD_CYCLES_DEFAULT,
   parameter int                          TIMEOUT     = 240000,
   parameter int                          TO_W        = 20
) (
   input  logic               ICE_CLK,
   input  logic               rst,
   input  logic               enable,
   input  logic [N_LINES-1:0] a_in,
   input  logic [N_LINES-1:0] b_in,
   output logic [N_LINES-1:0] a_oe,
   output logic [N_LINES-1:0] b_oe,
   output logic [N_LINES-1:0] active,
   output logic [N_LINES-1:0] dir,
   output logic [N_LINES-1:0] fault,
   input  logic               fault_clr
);

   for (genvar i = 0; i < N_LINES; i++) begin : g_line
      i2c_pt_line #(
         .FILT_LEN (FILT_LEN),
         .HOLD_LEN (HOLD_CYCLES[i*HOLD_W +: HOLD_W]),
         .TIMEOUT  (TIMEOUT),
         .TO_W     (TO_W)
      ) u_line (
         .clk       (ICE_CLK),
         .rst       (rst),
         .enable    (enable),
         .fault_clr (fault_clr),
         .a_in      (a_in[i]),
         .b_in      (b_in[i]),
         .a_oe      (a_oe[i]),
         .b_oe      (b_oe[i]),
         .active    (active[i]),
         .dir       (dir[i]),
         .fault     (fault[i])
      );
   end

endmodule
`default_nettype wire

// File: doc/i2c_passthrough_n.md
Name: i2c_passthrough_n

Overview:
- Parametrised, multi-line, bidirectional open-drain repeater between two buses, side A (RP2040) and side B (peripheral).
- Each line (e.g. SDA, SCL) is sensed on both sides. When one side is pulled low, the block drives the other side low until the originating side releases.
- Adds over the previous generation: input synchronisers, glitch filter, per-line release hold-off, stuck-low timeout with sticky fault, global enable and status outputs.
- Sits between the SB_IO instances (top level supplies *_in from D_IN_0 and *_oe to OUTPUT_ENABLE, D_OUT_0 tied 0) and the user logic.

Parameters:
- N_LINES, 2, number of independent open-drain lines (bit 0 SDA, bit 1 SCL by convention).
- FILT_LEN, 3, consecutive equal synchronised samples needed to change a filtered input; range 1..15.
- HOLD_CYCLES, {8'd15, 8'd7}, packed N_LINES×8 vector; per-line hold-off after release, line i at bits [8i+7:8i].
- TIMEOUT, 240000, max cycles in a drive state before forced release (20 ms at 12 MHz); 0 disables.
- TO_W, 20, timeout counter width; must satisfy TIMEOUT < 2^TO_W.

Ports:
- ICE_CLK  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  1 = passthrough active; 0 = all lines forced to IDLE, oe low.
- a_in  in  N_LINES  raw pin levels, side A.
- b_in  in  N_LINES  raw pin levels, side B.
- a_oe  out  N_LINES  1 = pull side A low (registered).
- b_oe  out  N_LINES  1 = pull side B low (registered).
- active  out  N_LINES  line state is not IDLE.
- dir  out  N_LINES  1 = A→B drive, 0 = B→A or idle.
- fault  out  N_LINES  sticky stuck-low flag.
- fault_clr  in  1  clears all fault bits (single-cycle pulse).

Behaviour:
- Reset: a_oe = b_oe = active = dir = fault = 0. Sync flops and filtered levels = 1. Line FSMs = IDLE. Counters = 0.
- Input path per pin: 2-flop synchroniser, then filter.
  - The filter output changes only after FILT_LEN consecutive synchronised samples differ from the current output.
  - Pin-low to oe-assert latency is exactly FILT_LEN+3 ICE_CLK edges.
- Per-line FSM: IDLE, A2B, B2A, HOLD, STUCK.
  - IDLE: if filtered A low, go to A2B. Else if filtered B low, go to B2A. If both are low in the same cycle, A wins.
  - A2B: b_oe=1, dir=1. Filtered A high → HOLD, load hold counter with HOLD_CYCLES[i].
  - B2A: a_oe=1. Filtered B high → HOLD.
  - Timeout (TIMEOUT≠0): count cycles in A2B/B2A; at count == TIMEOUT, go to STUCK and set fault[i].
  - HOLD: oe=0. Decrement to 0, then IDLE. Both sides are ignored while in HOLD. HOLD_CYCLES=0 gives a single HOLD cycle.
  - STUCK: oe=0. Wait until both filtered A and filtered B are high, then HOLD.
- Sampling: the driven side's own input is never used to leave a drive state, which prevents latch-up on the echoed low.
- enable=0: next cycle every FSM goes to IDLE, oe=0, counters cleared; fault is retained. Rising enable restarts from IDLE with the current filtered levels.
- Fault register:
  - fault_clr clears all bits.
  - If fault_clr and a new fault are in the same cycle, set wins.
  - fault is cleared only by rst or fault_clr.
- Lines are fully independent; there is no cross-line interaction.
- Reset mid-transfer: oe drops on the edge following rst=1.

Decomposition:
- Package i2c_pt_pkg holds:
  - line_state_t enum (IDLE, A2B, B2A, HOLD, STUCK), 3 bits
  - HOLD_W = 8
  - the default HOLD_CYCLES constant
- Sub-module i2c_pt_line: one line's synchronisers, filters, FSM, hold and timeout counters, fault flop. Generate N_LINES instances; the top slices HOLD_CYCLES and fans out enable/fault_clr.
- Target size: about 150 lines of RTL for the line module, about 60 for the top.

Test Plan:
- Reset then idle: all in = 1 for 100 cycles → all outputs 0.
- Line 0 A low for 50 cycles: b_oe[0] rises exactly FILT_LEN+3=6 edges after the drop, with dir[0]=1 and active[0]=1. After A releases, b_oe[0] falls after filter latency. active stays high for 7+1 hold cycles, and a B low during hold is ignored.
- 2-cycle glitch on a_in[1] with FILT_LEN=3 → no oe change on any line.
- a_in[0] and b_in[0] low on the same edge → b_oe[0]=1 and a_oe[0]=0 (A wins). Line 1 is unaffected.
- TIMEOUT=100, A held low for 500 cycles → b_oe deasserts at cycle ~100+latency, fault[0]=1, FSM in STUCK. Release A → HOLD then IDLE. fault_clr pulse → fault[0]=0.
- enable dropped mid-A2B → oe=0 the next cycle. rst pulse mid-B2A → all outputs 0 the next cycle.
